// File: rtl/alu_iterative_core_if.sv
// Request/response bundle for the iterative ALU.
// Master issues operations, slave returns results and flags.
interface alu_iterative_core_if #(
    parameter int WIDTH = 32
);
    logic             alu_start;
    logic [4:0]       alu_ctrl;
    logic [WIDTH-1:0] in_1;
    logic [WIDTH-1:0] in_2;
    logic             alu_ready;
    logic             alu_done;
    logic [WIDTH-1:0] alu_rslt;
    logic [WIDTH-1:0] alu_rslt_hi;
    logic [4:0]       alu_checks;

    modport master (
        output alu_start, alu_ctrl, in_1, in_2,
        input  alu_ready, alu_done,
        input  alu_rslt, alu_rslt_hi, alu_checks
    );

    modport slave (
        input  alu_start, alu_ctrl, in_1, in_2,
        output alu_ready, alu_done,
        output alu_rslt, alu_rslt_hi, alu_checks
    );
endinterface

// File: rtl/alu_iterative_core.sv
// Handshaked ALU: single-cycle arith/logic/shift ops plus
// iterative shift-add multiply and restoring divide.
module alu_iterative_core #(
    parameter int WIDTH = 32
) (
    input logic                 alu_clk,
    input logic                 alu_rst,
    alu_iterative_core_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH - 1);

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_ADDC = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_OR   = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_NOR  = 5'd6;
    localparam logic [4:0] OP_XNOR = 5'd7;
    localparam logic [4:0] OP_SHL  = 5'd8;
    localparam logic [4:0] OP_SHR  = 5'd9;
    localparam logic [4:0] OP_SAR  = 5'd10;
    localparam logic [4:0] OP_ROL  = 5'd11;
    localparam logic [4:0] OP_ROR  = 5'd12;
    localparam logic [4:0] OP_MUL  = 5'd13;
    localparam logic [4:0] OP_DIV  = 5'd14;

    typedef enum logic {
        S_IDLE,
        S_ITER
    } state_t;

    state_t state_q, state_n;

    logic             ready_q;
    logic             done_q;
    logic [WIDTH-1:0] rslt_q;
    logic [WIDTH-1:0] hi_q;
    logic [4:0]       chk_q;
    logic [WIDTH-1:0] acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic [WIDTH-1:0] opb_q;
    logic             div_q;
    logic [SHW:0]     cnt_q;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   sh;
    logic             cin;

    assign a   = bus.in_1;
    assign b   = bus.in_2;
    assign sh  = bus.in_2[SHW-1:0];
    assign cin = (bus.alu_ctrl == OP_ADDC) & chk_q[1];

    logic [WIDTH:0]     add_w;
    logic [WIDTH:0]     sub_w;
    logic [WIDTH:0]     shl_w;
    logic [WIDTH:0]     shr_w;
    logic [WIDTH:0]     sar_w;
    logic [2*WIDTH-1:0] rol_w;
    logic [2*WIDTH-1:0] ror_w;
    logic [WIDTH-1:0]   s_rslt;
    logic [WIDTH-1:0]   s_hi;
    logic [4:0]         s_chk;
    logic               s_iter;
    logic               s_v;
    logic               s_c;
    logic               s_undef;

    always_comb begin
        add_w   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        sub_w   = {1'b0, a} - {1'b0, b};
        shl_w   = {1'b0, a} << sh;
        shr_w   = {a, 1'b0} >> sh;
        sar_w   = $signed({a, 1'b0}) >>> sh;
        rol_w   = {a, a} << sh;
        ror_w   = {a, a} >> sh;
        s_rslt  = '0;
        s_hi    = '0;
        s_v     = 1'b0;
        s_c     = 1'b0;
        s_iter  = 1'b0;
        s_undef = 1'b0;
        case (bus.alu_ctrl)
            OP_ADD, OP_ADDC: begin
                s_rslt = add_w[WIDTH-1:0];
                s_c    = add_w[WIDTH];
                s_v    = (a[WIDTH-1] == b[WIDTH-1]) &&
                         (s_rslt[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                s_rslt = sub_w[WIDTH-1:0];
                s_c    = sub_w[WIDTH];
                s_v    = (a[WIDTH-1] != b[WIDTH-1]) &&
                         (s_rslt[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  s_rslt = a & b;
            OP_OR:   s_rslt = a | b;
            OP_XOR:  s_rslt = a ^ b;
            OP_NOR:  s_rslt = ~(a | b);
            OP_XNOR: s_rslt = ~(a ^ b);
            // Extra guard bit on each shift captures the last bit out
            OP_SHL: begin
                s_rslt = shl_w[WIDTH-1:0];
                s_c    = shl_w[WIDTH];
            end
            OP_SHR: begin
                s_rslt = shr_w[WIDTH:1];
                s_c    = shr_w[0];
            end
            OP_SAR: begin
                s_rslt = sar_w[WIDTH:1];
                s_c    = sar_w[0];
            end
            OP_ROL:  s_rslt = rol_w[2*WIDTH-1:WIDTH];
            OP_ROR:  s_rslt = ror_w[WIDTH-1:0];
            OP_MUL:  s_iter = 1'b1;
            OP_DIV: begin
                if (b == '0) begin
                    s_rslt = '1;
                    s_hi   = a;
                    s_v    = 1'b1;
                end else begin
                    s_iter = 1'b1;
                end
            end
            default: s_undef = 1'b1;
        endcase
        if (s_undef) begin
            s_chk = 5'b00100;
        end else begin
            s_chk = {^s_rslt, s_v, s_rslt == '0, s_c, s_rslt[WIDTH-1]};
        end
    end

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] it_hi;
    logic [WIDTH-1:0] it_lo;
    logic             mul_nz;
    logic [4:0]       it_chk;

    always_comb begin
        mul_sum  = {1'b0, acc_hi_q} +
                   (acc_lo_q[0] ? {1'b0, opb_q} : '0);
        div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, opb_q};
        div_ge   = div_sh >= {1'b0, opb_q};
        if (div_q) begin
            it_hi = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            it_lo = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
            it_hi = mul_sum[WIDTH:1];
            it_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        mul_nz = !div_q && (it_hi != '0);
        it_chk = {^it_lo, mul_nz, it_lo == '0, mul_nz, it_lo[WIDTH-1]};
    end

    logic accept;
    logic wr_single;
    logic step;
    logic finish;

    always_comb begin
        state_n   = state_q;
        accept    = 1'b0;
        wr_single = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.alu_start) begin
                    accept = 1'b1;
                    if (s_iter) begin
                        state_n = S_ITER;
                    end else begin
                        wr_single = 1'b1;
                    end
                end
            end
            S_ITER: begin
                step = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    finish  = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge alu_clk) begin
        if (alu_rst) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_n;
            ready_q <= (state_n == S_IDLE);
        end
    end

    always_ff @(posedge alu_clk) begin
        if (alu_rst) begin
            done_q   <= 1'b0;
            rslt_q   <= '0;
            hi_q     <= '0;
            chk_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opb_q    <= '0;
            div_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            done_q <= wr_single | finish;
            if (wr_single) begin
                rslt_q <= s_rslt;
                hi_q   <= s_hi;
                chk_q  <= s_chk;
            end
            // Both MUL and DIV start from {0, in_1} with in_2 as the operand
            if (accept && s_iter) begin
                acc_hi_q <= '0;
                acc_lo_q <= a;
                opb_q    <= b;
                div_q    <= (bus.alu_ctrl == OP_DIV);
                cnt_q    <= '0;
            end
            if (step) begin
                acc_hi_q <= it_hi;
                acc_lo_q <= it_lo;
                cnt_q    <= cnt_q + 1'b1;
            end
            if (finish) begin
                rslt_q <= it_lo;
                hi_q   <= it_hi;
                chk_q  <= it_chk;
            end
        end
    end

    assign bus.alu_ready   = ready_q;
    assign bus.alu_done    = done_q;
    assign bus.alu_rslt    = rslt_q;
    assign bus.alu_rslt_hi = hi_q;
    assign bus.alu_checks  = chk_q;
endmodule

// File: tb/tb_alu_iterative_core.sv
// Scoreboard bench for alu_iterative_core: directed cases,
// reset abort, ignored mid-op starts and randomised ops.
module tb_alu_iterative_core;
    localparam int W = 32;

    logic alu_clk = 1'b0;
    logic alu_rst;
    always #5 alu_clk = ~alu_clk;

    alu_iterative_core_if #(.WIDTH(W)) bus ();

    alu_iterative_core #(.WIDTH(W)) dut (
        .alu_clk (alu_clk),
        .alu_rst (alu_rst),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] r;
        logic [31:0] hi;
        logic [4:0]  chk;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t got_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    logic c_model;

    always @(posedge alu_clk) cyc <= cyc + 1;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge alu_clk) begin
        if (bus.alu_done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                got_e = sb.pop_front();
                check("rslt", bus.alu_rslt, got_e.r);
                check("rslt_hi", bus.alu_rslt_hi, got_e.hi);
                check("checks", bus.alu_checks, got_e.chk);
                check("done_cycle", cyc, got_e.cyc);
            end
        end
    end

    // Reference model; cyc field holds the extra latency in cycles
    function automatic exp_t model(logic [4:0] op, logic [31:0] a,
                                   logic [31:0] b, logic cin);
        exp_t        e;
        logic [63:0] p;
        logic [31:0] r;
        logic [31:0] h;
        logic        c;
        logic        v;
        logic        undef;
        int          sh;
        sh = int'(b[4:0]);
        r = 0; h = 0; c = 0; v = 0; undef = 0;
        e.cyc = 0;
        case (op)
            5'd0, 5'd2: begin
                p = {32'b0, a} + {32'b0, b} + {63'b0, (op == 5'd2) & cin};
                r = p[31:0];
                c = p[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            5'd1: begin
                r = a - b;
                c = a < b;
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            5'd3: r = a & b;
            5'd4: r = a | b;
            5'd5: r = a ^ b;
            5'd6: r = ~(a | b);
            5'd7: r = ~(a ^ b);
            5'd8: begin
                r = a << sh;
                c = (sh != 0) ? a[32-sh] : 1'b0;
            end
            5'd9: begin
                r = a >> sh;
                c = (sh != 0) ? a[sh-1] : 1'b0;
            end
            5'd10: begin
                r = $signed(a) >>> sh;
                c = (sh != 0) ? a[sh-1] : 1'b0;
            end
            5'd11: r = (sh == 0) ? a : ((a << sh) | (a >> (32 - sh)));
            5'd12: r = (sh == 0) ? a : ((a >> sh) | (a << (32 - sh)));
            5'd13: begin
                p = 64'(a) * 64'(b);
                r = p[31:0];
                h = p[63:32];
                c = (h != 0);
                v = c;
                e.cyc = 32;
            end
            5'd14: begin
                if (b == 0) begin
                    r = '1;
                    h = a;
                    v = 1'b1;
                end else begin
                    r = a / b;
                    h = a % b;
                    e.cyc = 32;
                end
            end
            default: undef = 1'b1;
        endcase
        e.r   = r;
        e.hi  = h;
        e.chk = undef ? 5'b00100 : {^r, v, r == 0, c, r[31]};
        return e;
    endfunction

    task automatic drive(input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int acc);
        int n;
        n = 0;
        while (bus.alu_ready !== 1'b1 && n < 100) begin
            @(negedge alu_clk);
            n++;
        end
        if (bus.alu_ready !== 1'b1) check("ready_timeout", 0, 1);
        bus.alu_start = 1'b1;
        bus.alu_ctrl  = op;
        bus.in_1      = a;
        bus.in_2      = b;
        @(posedge alu_clk);
        #1;
        bus.alu_start = 1'b0;
        acc = cyc;
    endtask

    task automatic issue_exp(input logic [4:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] r,
                             input logic [31:0] h, input logic [4:0] chk,
                             input int extra);
        int   acc;
        exp_t e;
        drive(op, a, b, acc);
        e.r   = r;
        e.hi  = h;
        e.chk = chk;
        e.cyc = acc + extra;
        sb.push_back(e);
        c_model = chk[1];
    endtask

    task automatic issue_model(input logic [4:0] op, input logic [31:0] a,
                               input logic [31:0] b);
        int   acc;
        exp_t e;
        e = model(op, a, b, c_model);
        drive(op, a, b, acc);
        e.cyc = e.cyc + acc;
        sb.push_back(e);
        c_model = e.chk[1];
    endtask

    initial begin
        int n;
        int acc;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        alu_rst       = 1'b1;
        bus.alu_start = 1'b0;
        bus.alu_ctrl  = '0;
        bus.in_1      = '0;
        bus.in_2      = '0;
        c_model       = 1'b0;
        repeat (2) @(posedge alu_clk);
        #1;
        alu_rst = 1'b0;
        check("rst_ready", bus.alu_ready, 1);
        check("rst_done", bus.alu_done, 0);
        check("rst_rslt", bus.alu_rslt, 0);
        check("rst_hi", bus.alu_rslt_hi, 0);
        check("rst_checks", bus.alu_checks, 0);

        // Back-to-back single-cycle directed cases
        issue_exp(5'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 5'b11001, 0);
        issue_exp(5'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 5'b00110, 0);
        issue_exp(5'd2, 32'd5, 32'd6, 32'd12, 0, 5'b00000, 0);
        issue_exp(5'd1, 32'd3, 32'd5, 32'hFFFFFFFE, 0, 5'b10011, 0);
        issue_exp(5'd8, 32'h80000001, 32'd1, 32'h2, 0, 5'b10010, 0);
        issue_exp(5'd20, 32'h1234, 32'h5678, 32'h0, 0, 5'b00100, 0);
        issue_exp(5'd14, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9, 5'b01001, 0);
        issue_model(5'd9, 32'hA5A5A5A5, 32'd0);
        issue_model(5'd10, 32'h80000001, 32'd31);
        issue_model(5'd11, 32'h80000001, 32'd4);
        issue_model(5'd12, 32'h80000001, 32'd4);

        // MUL with an ignored start pulse mid-operation
        issue_exp(5'd13, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'd1,
                  5'b11011, 32);
        n = 0;
        @(negedge alu_clk);
        while (bus.alu_ready !== 1'b1 && n < 200) begin
            n++;
            bus.alu_start = (n == 5);
            bus.alu_ctrl  = 5'd0;
            bus.in_1      = 32'd1;
            bus.in_2      = 32'd1;
            @(negedge alu_clk);
        end
        bus.alu_start = 1'b0;
        check("mul_ready_low", n, 32);

        issue_exp(5'd14, 32'd100, 32'd7, 32'd14, 32'd2, 5'b10000, 32);

        // Reset mid-MUL aborts and clears the stored carry
        issue_exp(5'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 5'b00110, 0);
        drive(5'd13, 32'h12345678, 32'h9ABCDEF0, acc);
        repeat (5) @(negedge alu_clk);
        alu_rst = 1'b1;
        repeat (2) @(posedge alu_clk);
        #1;
        check("mid_rst_ready", bus.alu_ready, 1);
        check("mid_rst_done", bus.alu_done, 0);
        check("mid_rst_rslt", bus.alu_rslt, 0);
        check("mid_rst_checks", bus.alu_checks, 0);
        alu_rst = 1'b0;
        c_model = 1'b0;
        repeat (40) @(negedge alu_clk);
        issue_exp(5'd2, 32'd5, 32'd6, 32'd11, 0, 5'b10000, 0);

        for (int i = 0; i < 40; i++) begin
            op = (i % 5 == 0) ? 5'($urandom_range(15, 31))
                              : 5'($urandom_range(0, 14));
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            issue_model(op, a, b);
        end

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge alu_clk);
            n++;
        end
        @(negedge alu_clk);
        check("sb_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
